// File: rtl/baud_tick_gen.sv
// UART baud tick generator: oversample, bit-rate and mid-bit enables for eight rates.
// Define BAUD_FRAC_EN to add Bresenham fractional correction so the average rate is exact.

module baud_tick_gen #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned CNT_W      = 14,
    parameter int unsigned ERR_W      = 21
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] baud_select,
    input  logic       resync,
    output logic       sample_ENABLE,
    output logic       bit_ENABLE,
    output logic       mid_ENABLE
);

    localparam int unsigned OVR_W = $clog2(OVERSAMPLE);

    function automatic longint unsigned rate_of(input int unsigned sel);
        case (sel)
            0:       return 64'd300;
            1:       return 64'd1200;
            2:       return 64'd4800;
            3:       return 64'd9600;
            4:       return 64'd19200;
            5:       return 64'd38400;
            6:       return 64'd57600;
            default: return 64'd115200;
        endcase
    endfunction

    function automatic longint unsigned n_of(input int unsigned sel);
        return longint'(OVERSAMPLE) * rate_of(sel);
    endfunction

    function automatic longint unsigned d_of(input int unsigned sel);
        return longint'(CLK_HZ) / n_of(sel);
    endfunction

    function automatic longint unsigned r_of(input int unsigned sel);
        return longint'(CLK_HZ) % n_of(sel);
    endfunction

    function automatic longint unsigned dr_of(input int unsigned sel);
        return (longint'(CLK_HZ) + n_of(sel) / 2) / n_of(sel);
    endfunction

    // Per-rate constants packed side by side, indexed by baud_select at run time.
    function automatic logic [8*CNT_W-1:0] pack_cnt(input bit rounded);
        logic [8*CNT_W-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            t[i*CNT_W +: CNT_W] = CNT_W'(rounded ? dr_of(i) : d_of(i));
        end
        return t;
    endfunction

    function automatic logic [8*ERR_W-1:0] pack_err(input bit want_n);
        logic [8*ERR_W-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            t[i*ERR_W +: ERR_W] = ERR_W'(want_n ? n_of(i) : r_of(i));
        end
        return t;
    endfunction

    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("baud_tick_gen: OVERSAMPLE must be even and at least 4");
    end
    if (d_of(7) < 2) begin : g_bad_clk
        $error("baud_tick_gen: CLK_HZ too low for 115200 bit/s (divisor below 2)");
    end
    if (n_of(7) >= (longint'(1) << ERR_W)) begin : g_bad_err_w
        $error("baud_tick_gen: ERR_W cannot hold OVERSAMPLE*115200");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic [2:0]       baud_q;
    logic             sample_q, sample_d;
    logic             bit_q, bit_d;
    logic             mid_q, mid_d;
    logic             restart;
    logic             tick;

    // A rate change, a resync or a disabled cycle all reload the phase exactly like reset.
    assign restart = !enable || (baud_select != baud_q) || resync;
    assign tick    = (cnt_q == period - CNT_W'(1));

    always_comb begin
        // NOTE: every target gets a default first so no path through the block can infer a latch.
        cnt_d    = cnt_q + CNT_W'(1);
        ovr_d    = ovr_q;
        sample_d = 1'b0;
        bit_d    = 1'b0;
        mid_d    = 1'b0;
        if (restart) begin
            cnt_d = '0;
            ovr_d = '0;
        end else if (tick) begin
            cnt_d    = '0;
            sample_d = 1'b1;
            bit_d    = (ovr_q == OVR_W'(OVERSAMPLE - 1));
            mid_d    = (ovr_q == OVR_W'(OVERSAMPLE / 2 - 1));
            ovr_d    = bit_d ? '0 : ovr_q + OVR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            cnt_q    <= '0;
            ovr_q    <= '0;
            sample_q <= 1'b0;
            bit_q    <= 1'b0;
            mid_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ovr_q    <= ovr_d;
            sample_q <= sample_d;
            bit_q    <= bit_d;
            mid_q    <= mid_d;
        end
    end

    // The shadow copy only serves change detection, so it simply follows the input.
    always_ff @(posedge clk) begin
        baud_q <= baud_select;
    end

`ifdef BAUD_FRAC_EN
    localparam logic [8*CNT_W-1:0] D_TAB = pack_cnt(1'b0);
    localparam logic [8*ERR_W-1:0] R_TAB = pack_err(1'b0);
    localparam logic [8*ERR_W-1:0] N_TAB = pack_err(1'b1);

    if (d_of(0) + 1 >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
        $error("baud_tick_gen: CNT_W cannot hold the 300 bit/s divisor");
    end

    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] d_new, d_cur;
    logic [ERR_W-1:0] err_q, err_d;
    logic [ERR_W-1:0] r_new, r_cur, n_cur;
    logic [ERR_W:0]   err_sum;

    assign d_new  = D_TAB[baud_select*CNT_W +: CNT_W];
    assign r_new  = R_TAB[baud_select*ERR_W +: ERR_W];
    assign d_cur  = D_TAB[baud_q*CNT_W +: CNT_W];
    assign r_cur  = R_TAB[baud_q*ERR_W +: ERR_W];
    assign n_cur  = N_TAB[baud_q*ERR_W +: ERR_W];
    assign period = per_q;

    // err and R are each below N, so their sum needs one extra bit.
    always_comb begin
        err_sum = {1'b0, err_q} + {1'b0, r_cur};
        per_d   = per_q;
        err_d   = err_q;
        if (restart) begin
            per_d = d_new;
            err_d = r_new;
        end else if (tick) begin
            if (err_sum >= {1'b0, n_cur}) begin
                per_d = d_cur + CNT_W'(1);
                err_d = ERR_W'(err_sum - {1'b0, n_cur});
            end else begin
                per_d = d_cur;
                err_d = err_sum[ERR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            per_q <= d_new;
            err_q <= r_new;
        end else begin
            per_q <= per_d;
            err_q <= err_d;
        end
    end
`else
    localparam logic [8*CNT_W-1:0] DR_TAB = pack_cnt(1'b1);

    if (dr_of(0) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
        $error("baud_tick_gen: CNT_W cannot hold the 300 bit/s divisor");
    end

    assign period = DR_TAB[baud_q*CNT_W +: CNT_W];
`endif

    assign sample_ENABLE = sample_q;
    assign bit_ENABLE    = bit_q;
    assign mid_ENABLE    = mid_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: tick-time reference model plus directed phase and rate scenarios.
// Honours BAUD_FRAC_EN the same way the design does.

module tb_baud_tick_gen;

    localparam longint CLK = 50000000;
    localparam longint OS  = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic       resync = 1'b0;
    logic [2:0] baud_select = 3'd3;
    logic       sample_ENABLE, bit_ENABLE, mid_ENABLE;

    int     n_checks = 0;
    int     n_fail = 0;
    longint cyc = 0;
    longint m_load = 0;
    longint m_k = 0;
    logic [2:0] m_sel = 3'd0;
    logic [2:0] m_exp = 3'd0;

    baud_tick_gen dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .baud_select  (baud_select),
        .resync       (resync),
        .sample_ENABLE(sample_ENABLE),
        .bit_ENABLE   (bit_ENABLE),
        .mid_ENABLE   (mid_ENABLE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint rate(input int s);
        case (s)
            0: return 300;
            1: return 1200;
            2: return 4800;
            3: return 9600;
            4: return 19200;
            5: return 38400;
            6: return 57600;
            default: return 115200;
        endcase
    endfunction

    // Cycles from a load edge to the k-th sample tick (k >= 1).
    function automatic longint t_of(input int s, input longint k);
        longint n;
        n = OS * rate(s);
`ifdef BAUD_FRAC_EN
        return (CLK / n) * k + ((CLK % n) * k) / n;
`else
        return ((CLK + n / 2) / n) * k;
`endif
    endfunction

    // Reference model: after each load, ticks fall at fixed offsets; every output compared each cycle.
    always @(posedge clk) begin
        cyc++;
        if (reset || !enable || resync || baud_select != m_sel) begin
            m_sel  = baud_select;
            m_load = cyc;
            m_k    = 0;
            m_exp  = 3'b000;
        end else if (cyc - m_load == t_of(int'(m_sel), m_k + 1)) begin
            m_k++;
            m_exp = {1'b1, (m_k % OS) == 0, (m_k % OS) == OS / 2};
        end else begin
            m_exp = 3'b000;
        end
        #1;
        check("outs", 64'({sample_ENABLE, bit_ENABLE, mid_ENABLE}), 64'(m_exp));
    end

    // which: 0 = sample, 1 = bit, 2 = mid; at = -1 if the budget runs out.
    task automatic wait_pulse(input int which, input int budget, output longint at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((which == 0 && sample_ENABLE) || (which == 1 && bit_ENABLE) ||
                (which == 2 && mid_ENABLE)) begin
                at = cyc;
                return;
            end
        end
    endtask

    longint sweep_p [8] = '{10417, 2604, 651, 326, 163, 81, 54, 27};

    initial begin
        longint at, prev, l;

        repeat (3) @(negedge clk);
        check("rst_outs", 64'({sample_ENABLE, bit_ENABLE, mid_ENABLE}), 64'd0);
        reset = 1'b0;
        l = cyc;
        wait_pulse(0, 400, at);
        check("first_sample", 64'(at - l), 64'(t_of(3, 1)));
        prev = at;
        wait_pulse(0, 400, at);
        check("second_sample", 64'(at - prev), 64'(t_of(3, 2) - t_of(3, 1)));
        wait_pulse(2, 3000, at);
        check("first_mid", 64'(at - l), 64'(t_of(3, 8)));
        wait_pulse(1, 3000, at);
        check("first_bit", 64'(at - l), 64'(t_of(3, 16)));
        prev = at;
        wait_pulse(1, 5400, at);
        check("bit_period", 64'(at - prev), 64'(t_of(3, 32) - t_of(3, 16)));

        // Rate sweep: each change reloads, so the first tick lands one period later.
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            baud_select = 3'(s);
            @(negedge clk);
            l = cyc;
            wait_pulse(0, 11000, at);
`ifdef BAUD_FRAC_EN
            check($sformatf("sweep_%0d", s), 64'(at - l), 64'(t_of(s, 1)));
`else
            check($sformatf("sweep_%0d", s), 64'(at - l), 64'(sweep_p[s]));
`endif
        end

        // Resync mid-stream at 115200.
        repeat (100) @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        l = cyc;
        wait_pulse(0, 100, at);
        check("resync_first", 64'(at - l), 64'd27);

        // Resync landing on the tick edge wins.
        repeat (t_of(7, 2) - t_of(7, 1) - 1) @(negedge clk);
        resync = 1'b1;
        @(negedge clk);
        resync = 1'b0;
        l = cyc;
        check("resync_wins", 64'(sample_ENABLE), 64'd0);
        wait_pulse(2, 400, at);
        check("resync_mid", 64'(at - l), 64'(t_of(7, 8)));

        // Rate change 7 -> 0 on the edge of the next pending tick.
        repeat (t_of(7, 9) - t_of(7, 8) - 1) @(negedge clk);
        baud_select = 3'd0;
        @(negedge clk);
        l = cyc;
        check("chg_drop", 64'(sample_ENABLE), 64'd0);
        wait_pulse(0, 11000, at);
`ifdef BAUD_FRAC_EN
        check("chg_first", 64'(at - l), 64'd10416);
        prev = at;
        wait_pulse(0, 11000, at);
        check("frac_p2", 64'(at - prev), 64'd10417);
        prev = at;
        wait_pulse(0, 11000, at);
        check("frac_p3", 64'(at - prev), 64'd10417);
`else
        check("chg_first", 64'(at - l), 64'd10417);
`endif

        // Disabled for 50 cycles: outputs stay low, counting restarts on re-enable.
        @(negedge clk);
        baud_select = 3'd7;
        enable = 1'b0;
        repeat (50) begin
            @(negedge clk);
            check("en_low", 64'({sample_ENABLE, bit_ENABLE, mid_ENABLE}), 64'd0);
        end
        enable = 1'b1;
        l = cyc;
        wait_pulse(0, 100, at);
        check("en_resume", 64'(at - l), 64'(t_of(7, 1)));
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        l = cyc;
        wait_pulse(0, 100, at);
        check("rst_first", 64'(at - l), 64'(t_of(7, 1)));

        // Randomised rate, enable and resync activity; the model checks every cycle.
        for (int it = 0; it < 20; it++) begin
            baud_select = 3'(3 + $urandom_range(0, 4));
            enable = ($urandom_range(0, 7) != 0);
            for (int c = 0; c < int'($urandom_range(50, 400)); c++) begin
                @(negedge clk);
                resync = ($urandom_range(0, 99) == 0);
            end
            resync = 1'b0;
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Parametrised baud-rate tick generator for the UART, replacing the fixed single-output sample-enable generator. From one system clock it produces the oversampling tick for the receiver, a bit-rate tick for the transmitter, and a mid-bit tick for receiver data sampling. Eight rates (300–115200 bit/s) are selected by `baud_select`, with divisors derived from parameters. Both UART datapaths sit downstream, and the receiver drives `resync` on start-bit detection.

## Interface
- `CLK_HZ`, 50000000: system clock frequency in Hz.
- `OVERSAMPLE`, 16: sample ticks per bit; even, ≥4.
- `CNT_W`, 14: divisor counter width. Must hold the 300 bit/s divisor.
- `ERR_W`, 21: fractional error accumulator width. Must hold `OVERSAMPLE*115200`.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: run when 1. When 0, hold all counters at their load values; all tick outputs are 0.
- `baud_select` in 3: 0..7 selects 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 bit/s.
- `resync` in 1: 1-cycle pulse that restarts the tick phase.
- `sample_ENABLE` out 1: 1-cycle pulse at `OVERSAMPLE` × baud rate.
- `bit_ENABLE` out 1: 1-cycle pulse once per bit period.
- `mid_ENABLE` out 1: 1-cycle pulse at mid-bit.

## Operation
- Per rate r, `N = OVERSAMPLE*r`.
- Integer divisor `D = CLK_HZ / N` (floor) and remainder `R = CLK_HZ mod N`, both elaboration-time constants.
- Rounded divisor `DR = (CLK_HZ + N/2) / N`.
- Elaboration check: `D ≥ 2` at 115200; otherwise elaboration fails.
- **Divisor counter `cnt`:**
  - Counts 0..P−1, where P is the current period.
  - When `cnt == P−1`: `cnt ← 0` and `sample_ENABLE ← 1`.
  - Otherwise: `cnt ← cnt+1` and `sample_ENABLE ← 0`.
- **Oversample counter `ovr`:**
  - Range 0..OVERSAMPLE−1; advances only on sample ticks and wraps to 0.
  - `bit_ENABLE ← 1` on the sample tick at which `ovr == OVERSAMPLE−1`.
  - `mid_ENABLE ← 1` on the sample tick at which `ovr == OVERSAMPLE/2−1`.
  - Both pulses are registered in the same cycle as the coincident `sample_ENABLE`.
- **Restart / load event:** any of `reset`, `resync`, or a change of `baud_select`.
  - A change is detected by comparing against a registered copy of `baud_select`.
  - On a load event: `cnt ← 0`, `ovr ← 0`, all ticks ← 0, and P/err are loaded (see Configuration).
  - Priority: `reset` > baud change > `resync` > normal count. All three have identical effect.
- **`enable` deasserted:** performs the same load as a restart. Counting resumes from zero on the first enabled cycle.

## Timing
- Reset values: `sample_ENABLE`, `bit_ENABLE`, `mid_ENABLE` = 0; `cnt`, `ovr` = 0.
- **Sample ticks after a load event:** with `enable` = 1 from the cycle after the load,
  - the first `sample_ENABLE` is high P cycles after that load edge;
  - subsequent sample pulses are exactly P cycles apart.
- **Bit ticks:** the first `mid_ENABLE` coincides with the (OVERSAMPLE/2)-th sample tick. The first `bit_ENABLE` coincides with the OVERSAMPLE-th sample tick.
- **`resync` coinciding with a tick cycle:** `resync` wins; no tick is issued and the phase restarts.
- **`baud_select` change:** the old rate's pending tick is dropped. The new rate takes effect with zero partial count.
- **Output pulses:** never longer than 1 cycle. `enable` = 0 forces all outputs low on the next edge.

## Configuration
- Macro: `BAUD_FRAC_EN`.
- **Undefined:** P = DR for the selected rate, constant.
- **Defined:** Bresenham fractional correction of the period.
  - On each load: P ← D and `err ← R`.
  - On each sample tick: if `err+R ≥ N`, then P ← D+1 and `err ← err+R−N`; otherwise P ← D and `err ← err+R`.
  - The average period equals `CLK_HZ/N` exactly, with no long-term drift.
  - At 300 bit/s and 50 MHz (D = 10416, R = 3200, N = 4800), periods after load are 10416, 10417, 10417, repeating.

## Test plan
- Reset, `baud_select=3`, `enable=1`, macro off → `sample_ENABLE` period 326 cycles; `bit_ENABLE` every 5216 cycles; `mid_ENABLE` 2608 cycles after load.
- Sweep `baud_select` 0..7, macro off → sample periods 10417, 2604, 651, 326, 163, 81, 54, 27.
- Macro on, `baud_select=0` → periods 10416, 10417, 10417, repeating; 3000 consecutive ticks span exactly 31250000 cycles.
- `resync` pulse 100 cycles into a period at `baud_select=7` → no tick at the old phase; next `sample_ENABLE` 27 cycles after the `resync` edge.
- `baud_select` 7→0 mid-bit, same cycle as a pending tick → tick suppressed; next `sample_ENABLE` after 10417 cycles; `ovr` restarts.
- `enable` low for 50 cycles, then `reset` mid-period with `enable` high → all outputs 0 throughout; first `sample_ENABLE` exactly P cycles after the `reset` edge.
